vga_fetch_buffer: RTL and testbench

Framebuffer prefetch stage sitting directly downstream of the SDRAM RAM controller's VGA read port. Issues 16-word burst reads (`vga_ren`/`vga_addr`), captures returned words into an internal FIFO, and serves them one word per `pix_rd` to the VGA timing/pixel unit. Walks the framebuffer linearly with wrap at frame end and resynchronises on `frame_start`.

---
 rtl/vga_fetch_buffer.sv | 97 +++++++++
 tb/tb_vga_fetch_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_buffer.sv
// vga_fetch_buffer: burst prefetch from the SDRAM VGA read port into a word FIFO for the pixel unit
module vga_fetch_buffer #(
    parameter logic [31:0] FB_BASE     = 32'h0000_0000,
    parameter int          FRAME_WORDS = 153600,
    parameter int          BURST_WORDS = 16,
    parameter int          FIFO_DEPTH  = 64
) (
    input  logic                          sdram_clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          pix_rd,
    output logic [31:0]                   pix_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          vga_ren,
    output logic [31:0]                   vga_addr,
    input  logic                          vga_ack,
    input  logic [31:0]                   mem_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam logic [31:0] FB_END = FB_BASE + 32'(FRAME_WORDS);
    localparam logic [31:0] BURST = 32'(BURST_WORDS);
    localparam logic [AW:0] CREDIT = (AW + 1)'(FIFO_DEPTH - BURST_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [BW-1:0] beat;
    logic [31:0]   next_addr, addr_inc;
    logic          start, beat_ev, last, push, pop;

    assign fifo_level = wr_ptr - rd_ptr;
    assign start      = state == IDLE && !frame_start && fifo_level <= CREDIT;
    assign beat_ev    = state != IDLE && vga_ack;
    assign last       = beat_ev && beat == BW'(BURST_WORDS - 1);
    assign push       = vga_ack && (state == REQ || state == RECV) && !frame_start;
    assign pop        = pix_rd && !frame_start && fifo_level != '0;
    assign addr_inc   = next_addr + BURST;

    // state register
    always_ff @(posedge sdram_clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // next state: a flush mid-burst keeps counting beats in DRAIN so the latched burst is consumed
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = start ? REQ : IDLE;
        else if (last) state_nx = IDLE;
        else if (frame_start) state_nx = DRAIN;
        else if (state == REQ && vga_ack) state_nx = RECV;
    end

    // request handshake, beat counter and linear framebuffer walk with frame wrap
    always_ff @(posedge sdram_clk or posedge reset)
        if (reset) begin
            vga_ren   <= 1'b0;
            vga_addr  <= FB_BASE;
            next_addr <= FB_BASE;
            beat      <= '0;
        end else begin
            if (start) begin
                vga_ren  <= 1'b1;
                vga_addr <= next_addr;
            end else if (beat_ev) vga_ren <= 1'b0;
            beat <= last ? '0 : beat_ev ? beat + BW'(1) : beat;
            if (frame_start) next_addr <= FB_BASE;
            else if (last && state != DRAIN) next_addr <= addr_inc == FB_END ? FB_BASE : addr_inc;
        end

    // FIFO storage; written only while a live burst is being received
    always_ff @(posedge sdram_clk)
        if (push) mem[wr_ptr[AW-1:0]] <= mem_data;

    // FIFO pointers, registered pop output and sticky underflow; flush has priority over pop
    always_ff @(posedge sdram_clk or posedge reset)
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pix_data  <= '0;
            underflow <= 1'b0;
        end else begin
            if (frame_start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                underflow <= 1'b0;
            end else begin
                wr_ptr    <= wr_ptr + (AW + 1)'(push);
                rd_ptr    <= rd_ptr + (AW + 1)'(pop);
                underflow <= underflow | (pix_rd && fifo_level == '0);
            end
            if (pix_rd) pix_data <= pop ? mem[rd_ptr[AW-1:0]] : '0;
        end
endmodule

// File: tb/tb_vga_fetch_buffer.sv
// tb_vga_fetch_buffer: randomized stimulus checked against a queue-based reference model
module tb_vga_fetch_buffer;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          FRAME = 128;
    localparam int          BURST = 16;
    localparam int          DEPTH = 64;

    logic        clk = 0, reset = 1, frame_start = 0, pix_rd = 0, vga_ack = 0;
    logic [31:0] mem_data = 0;
    logic [31:0] pix_data, vga_addr;
    logic [6:0]  fifo_level;
    logic        underflow, vga_ren;

    vga_fetch_buffer #(.FB_BASE(BASE), .FRAME_WORDS(FRAME), .BURST_WORDS(BURST), .FIFO_DEPTH(DEPTH)) dut (
        .sdram_clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .fifo_level(fifo_level), .underflow(underflow),
        .vga_ren(vga_ren), .vga_addr(vga_addr), .vga_ack(vga_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [31:0] q[$];
    logic [31:0] exp_pix = 0, exp_addr = BASE;
    logic        uf = 0;
    logic        ren_obs = 0;
    logic [31:0] addr_obs = 0;
    logic        c_busy = 0, c_drop = 0;
    int          c_lat = 0, c_beat = 0, gap_pct = 0, n_req = 0, n0 = 0;
    logic [31:0] c_addr = 0;
    logic [31:0] req_log[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hD0A5, a[15:0]};
    endfunction

    function automatic logic [31:0] addr_after(input logic [31:0] a);
        return (a + 32'(BURST) == BASE + 32'(FRAME)) ? BASE : a + 32'(BURST);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_pix = 0; exp_addr = BASE; uf = 0;
        c_busy = 0; c_drop = 0; c_beat = 0; c_lat = 0;
        ren_obs = 0; vga_ack = 0;
    endtask

    task automatic model_step();
        if (!c_busy && ren_obs) begin
            c_busy = 1; c_drop = 0; c_lat = 3; c_beat = 0; c_addr = addr_obs;
            n_req++;
            req_log.push_back(addr_obs);
            chk("req_addr", addr_obs, exp_addr);
            chk("req_credit", 32'(q.size() + BURST <= DEPTH), 32'd1);
        end
        if (frame_start) begin
            q.delete();
            uf = 0;
            if (pix_rd) exp_pix = 0;
            exp_addr = BASE;
            if (c_busy) c_drop = 1;
        end else if (pix_rd) begin
            if (q.size() == 0) begin
                exp_pix = 0;
                uf = 1;
            end else exp_pix = q.pop_front();
        end
        if (vga_ack) begin
            if (!c_drop) q.push_back(mem_data);
            c_beat++;
            if (c_beat == BURST) begin
                c_busy = 0;
                if (!c_drop) exp_addr = addr_after(c_addr);
            end
        end
    endtask

    task automatic drive_ctrl();
        if (c_busy && c_lat > 0) c_lat--;
        vga_ack = c_busy && c_lat == 0 && c_beat < BURST && $urandom_range(0, 99) >= gap_pct;
        mem_data = vga_ack ? word_of(c_addr + 32'(c_beat)) : $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        ren_obs = vga_ren;
        addr_obs = vga_addr;
        drive_ctrl();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ren"}, 32'(vga_ren), 0);
        chk({tag, "_addr"}, vga_addr, BASE);
        chk({tag, "_pix"}, pix_data, 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    // cycle-by-cycle comparison of observable outputs against the model
    always @(negedge clk)
        if (!reset) begin
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("pix_data", pix_data, exp_pix);
            chk("underflow", 32'(underflow), 32'(uf));
        end

    initial begin
        repeat (3) tick();
        chk_reset_values("reset");
        #2 reset = 0;

        repeat (120) tick();
        chk("fill_req_count", n_req, 4);
        for (int i = 0; i < 4; i++)
            chk("fill_req_addr", i < req_log.size() ? req_log[i] : 32'hFFFF_FFFF, 32'(i * 16));
        chk("fill_level", 32'(fifo_level), 64);
        chk("fill_no_fifth", 32'(vga_ren), 0);

        pix_rd = 1;
        tick();
        chk("first_pop", pix_data, 32'hD0A5_0000);
        repeat (15) tick();
        chk("sixteenth_pop", pix_data, 32'hD0A5_000F);
        pix_rd = 0;
        for (int i = 0; i < 20 && n_req < 5; i++) tick();
        chk("req_after_pop", req_log.size() > 4 ? req_log[4] : 32'hFFFF_FFFF, 32'h40);

        gap_pct = 20;
        for (int i = 0; i < 2000 && n_req < 9; i++) begin
            pix_rd = $urandom_range(0, 99) < 70;
            tick();
        end
        pix_rd = 0;
        chk("req_before_wrap", req_log.size() > 8 ? req_log[7] : 32'hFFFF_FFFF, 32'h70);
        chk("req_wrap", req_log.size() > 8 ? req_log[8] : 32'hFFFF_FFFF, 32'h0);

        gap_pct = 0;
        for (int i = 0; i < 400 && !(c_busy && vga_ack && c_beat == 4); i++) begin
            pix_rd = $urandom_range(0, 99) < 60;
            tick();
        end
        chk("fs_beat5_reached", 32'(c_busy && vga_ack && c_beat == 4), 1);
        pix_rd = 0;
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("fs_level", 32'(fifo_level), 0);
        for (int i = 0; i < 40 && c_busy; i++) tick();
        chk("drain_done", 32'(c_busy), 0);
        chk("drain_level", 32'(fifo_level), 0);
        n0 = n_req;
        for (int i = 0; i < 10 && n_req == n0; i++) tick();
        chk("fs_req_count", n_req, n0 + 1);
        chk("fs_req_addr", req_log.size() > 0 ? req_log[$] : 32'hFFFF_FFFF, BASE);

        pix_rd = 1;
        tick();
        pix_rd = 0;
        chk("empty_pop_data", pix_data, 0);
        chk("empty_pop_underflow", 32'(underflow), 1);
        for (int i = 0; i < 40 && c_busy; i++) tick();
        pix_rd = 1;
        tick();
        pix_rd = 0;
        chk("frame_word0", pix_data, 32'hD0A5_0000);
        chk("underflow_sticky", 32'(underflow), 1);
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("underflow_cleared", 32'(underflow), 0);
        chk("flush_level", 32'(fifo_level), 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) gap_pct = $urandom_range(0, 40);
            pix_rd = $urandom_range(0, 99) < 30 + (i / 500) * 12;
            frame_start = $urandom_range(0, 399) == 0;
            tick();
        end
        pix_rd = 0;
        frame_start = 0;

        for (int i = 0; i < 400 && !(c_busy && c_beat == 8); i++) begin
            pix_rd = $urandom_range(0, 99) < 60;
            tick();
        end
        pix_rd = 0;
        chk("mid_recv_reached", 32'(c_busy && c_beat == 8), 1);
        #1 reset = 1;
        #1;
        chk_reset_values("async_reset");
        model_reset();
        repeat (3) tick();
        #2 reset = 0;
        n0 = n_req;
        for (int i = 0; i < 10 && n_req == n0; i++) tick();
        chk("post_reset_req_count", n_req, n0 + 1);
        chk("post_reset_req_addr", req_log.size() > 0 ? req_log[$] : 32'hFFFF_FFFF, BASE);
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
